// File: rtl/rx_hp_pkg.sv
// Shared constants, FSM encoding and byte-swap helper for the RX huge-page address bank.
package rx_hp_pkg;

  localparam logic [6:0] FmtMwr32 = 7'b10_00000;
  localparam logic [6:0] FmtMwr64 = 7'b11_00000;

  localparam int unsigned AddrDwBaseDef   = 16;
  localparam int unsigned UnlockDwBaseDef = 24;
  localparam int unsigned PageW           = 3;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData,
    StDrain
  } state_e;

  // TLP payload is big-endian per DW; TLP byte 0 lands in bits [7:0].
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/hp_status_bank.sv
// Per-page ownership flags: set by unlock doorbells, cleared by free strobes, set wins.
module hp_status_bank #(
  parameter int unsigned NUM_PAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PAGES-1:0] i_set,
  input  logic [NUM_PAGES-1:0] i_clr,
  output logic [NUM_PAGES-1:0] o_status
);

  logic [NUM_PAGES-1:0] r_status;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_status <= '0;
    end else begin
      r_status <= i_set | (r_status & ~i_clr);
    end
  end

  assign o_status = r_status;

endmodule

// File: rtl/rx_huge_pages_addr_bank.sv
// Snoops TRN RX memory writes for huge-page address registers and unlock doorbells.
// Define RX_HP_MEM_WR64_EN to also decode 4DW MWr64 TLPs; otherwise they are drained.
module rx_huge_pages_addr_bank
  import rx_hp_pkg::*;
#(
  parameter int unsigned NUM_PAGES      = 2,
  parameter int unsigned BAR_IDX        = 2,
  parameter int unsigned ADDR_DW_BASE   = AddrDwBaseDef,
  parameter int unsigned UNLOCK_DW_BASE = UnlockDwBaseDef
) (
  input  logic                    trn_clk,
  input  logic                    reset_n,
  input  logic [63:0]             trn_rd,
  input  logic [7:0]              trn_rrem_n,
  input  logic                    trn_rsof_n,
  input  logic                    trn_reof_n,
  input  logic                    trn_rsrc_rdy_n,
  input  logic                    trn_rsrc_dsc_n,
  input  logic [6:0]              trn_rbar_hit_n,
  input  logic                    trn_rdst_rdy_n,
  output logic [64*NUM_PAGES-1:0] huge_page_addr,
  output logic [NUM_PAGES-1:0]    huge_page_status,
  input  logic [NUM_PAGES-1:0]    huge_page_free
);

`ifdef RX_HP_MEM_WR64_EN
  localparam bit Wr64En = 1'b1;
`else
  localparam bit Wr64En = 1'b0;
`endif

  logic w_beat, w_sof, w_eof, w_abort, w_bar;
  logic [6:0] w_fmt;
  logic [5:0] w_off;
  logic w_unused;

  assign w_beat   = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign w_sof    = ~trn_rsof_n;
  assign w_eof    = ~trn_reof_n;
  assign w_abort  = ~trn_rsrc_dsc_n;
  assign w_bar    = ~trn_rbar_hit_n[BAR_IDX];
  assign w_fmt    = trn_rd[62:56];
  assign w_unused = ^{trn_rrem_n, trn_rbar_hit_n};

  state_e             r_state;
  logic               r_is64, r_doorbell;
  logic [9:0]         r_len;
  logic [PageW-1:0]   r_page;
  logic [31:0]        r_dw0;
  logic [63:0]        r_addr [NUM_PAGES];

  assign w_off = r_is64 ? trn_rd[7:2] : trn_rd[39:34];

  logic             w_addr_hit, w_unlock_hit;
  logic [PageW-1:0] w_hit_page, w_unlock_page;

  // Only low-DW address offsets count as hits; high-DW alone is ignored.
  always_comb begin
    w_addr_hit    = 1'b0;
    w_unlock_hit  = 1'b0;
    w_hit_page    = '0;
    w_unlock_page = '0;
    for (int unsigned i = 0; i < NUM_PAGES; i++) begin
      if (w_off == 6'(ADDR_DW_BASE + 2 * i)) begin
        w_addr_hit = 1'b1;
        w_hit_page = PageW'(i);
      end
      if (w_off == 6'(UNLOCK_DW_BASE + i)) begin
        w_unlock_hit  = 1'b1;
        w_unlock_page = PageW'(i);
      end
    end
  end

  logic                 w_commit;
  logic [PageW-1:0]     w_commit_page;
  logic [63:0]          w_commit_val;
  logic [NUM_PAGES-1:0] w_set;
  logic [31:0]          w_hi_sw, w_lo_sw;

  assign w_hi_sw = bswap32(trn_rd[63:32]);
  assign w_lo_sw = bswap32(trn_rd[31:0]);

  always_comb begin
    w_commit      = 1'b0;
    w_commit_page = r_page;
    w_commit_val  = '0;
    w_set         = '0;
    if (w_beat && !w_abort) begin
      if (r_state == StHdr && !r_is64) begin
        if (w_addr_hit && r_len == 10'd1) begin
          w_commit      = 1'b1;
          w_commit_page = w_hit_page;
          w_commit_val  = {32'h0, w_lo_sw};
        end
        for (int unsigned i = 0; i < NUM_PAGES; i++) begin
          if (w_unlock_hit && w_unlock_page == PageW'(i)) w_set[i] = 1'b1;
        end
      end
      if (r_state == StData) begin
        if (r_doorbell) begin
          for (int unsigned i = 0; i < NUM_PAGES; i++) begin
            if (r_page == PageW'(i)) w_set[i] = 1'b1;
          end
        end else begin
          w_commit = 1'b1;
          if (!r_is64)              w_commit_val = {w_hi_sw, r_dw0};
          else if (r_len == 10'd1)  w_commit_val = {32'h0, w_hi_sw};
          else                      w_commit_val = {w_lo_sw, w_hi_sw};
        end
      end
    end
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_is64     <= 1'b0;
      r_doorbell <= 1'b0;
      r_len      <= '0;
      r_page     <= '0;
      r_dw0      <= '0;
      for (int unsigned i = 0; i < NUM_PAGES; i++) r_addr[i] <= '0;
    end else begin
      if (w_beat) begin
        case (r_state)
          StIdle: begin
            if (w_sof && w_bar) begin
              r_len      <= trn_rd[41:32];
              r_is64     <= (w_fmt == FmtMwr64);
              r_doorbell <= 1'b0;
              if (!w_abort && !w_eof &&
                  (w_fmt == FmtMwr32 || (Wr64En && w_fmt == FmtMwr64))) begin
                r_state <= StHdr;
              end else if (!w_eof) begin
                r_state <= StDrain;
              end
            end
          end
          StHdr: begin
            r_page     <= w_unlock_hit ? w_unlock_page : w_hit_page;
            r_doorbell <= w_unlock_hit;
            r_dw0      <= w_lo_sw;
            // MWr64 carries no data here; MWr32 needs a second beat only for DW1.
            if (!w_abort && !w_eof &&
                (r_is64 ? (w_addr_hit || w_unlock_hit) : (w_addr_hit && r_len != 10'd1))) begin
              r_state <= StData;
            end else begin
              r_state <= w_eof ? StIdle : StDrain;
            end
          end
          StData:  r_state <= w_eof ? StIdle : StDrain;
          StDrain: if (w_eof) r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
      for (int unsigned i = 0; i < NUM_PAGES; i++) begin
        if (w_commit && w_commit_page == PageW'(i)) r_addr[i] <= w_commit_val;
      end
    end
  end

  for (genvar g = 0; g < NUM_PAGES; g++) begin : g_addr
    assign huge_page_addr[64*g +: 64] = r_addr[g];
  end

  hp_status_bank #(
    .NUM_PAGES(NUM_PAGES)
  ) u_status (
    .i_clk    (trn_clk),
    .i_rst_n  (reset_n),
    .i_set    (w_set),
    .i_clr    (huge_page_free),
    .o_status (huge_page_status)
  );

endmodule
